// File: rtl/dsp_sched_pkg.sv
// Shared types and constants for the DSP MAC job scheduler.
package dsp_sched_pkg;

  localparam int unsigned A_W = 20;
  localparam int unsigned B_W = 18;
  localparam int unsigned Z_W = 38;

  localparam logic [2:0] FB_ACC = 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    RESULT
  } state_e;

endpackage

// File: rtl/dsp_sched_rr_arb.sv
// Combinational round-robin arbiter: the search for a request starts at the pointer
// and wraps around.
module dsp_sched_rr_arb #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_k = IDW'((32'(i_ptr) + i) % NREQ);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/dsp_mac_job_scheduler.sv
// Shares one DSP MAC slice between NREQ dot-product job streams, returning tagged sums.
// Optional output shift/round/saturate control is enabled by defining DSP_MAC_SCHED_SHIFT_EN.
module dsp_mac_job_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DSP_LAT = 1,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*A_W-1:0] req_a_i,
  input  logic [NREQ*B_W-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_last_i,
  input  logic              cfg_unsigned_a_i,
  input  logic              cfg_unsigned_b_i,
  input  logic [5:0]        cfg_shift_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [Z_W-1:0]    res_data_o,
  output logic [IDW-1:0]    res_id_o,
  output logic [CNT_W-1:0]  res_count_o,
  output logic [A_W-1:0]    dsp_a_o,
  output logic [B_W-1:0]    dsp_b_o,
  output logic [2:0]        dsp_feedback_o,
  output logic              dsp_load_acc_o,
  output logic              dsp_unsigned_a_o,
  output logic              dsp_unsigned_b_o,
  output logic              dsp_saturate_o,
  output logic              dsp_round_o,
  output logic              dsp_subtract_o,
  output logic [5:0]        dsp_shift_right_o,
  input  logic [Z_W-1:0]    dsp_z_i
);

  localparam int unsigned LAT_W = (DSP_LAT > 0) ? $clog2(DSP_LAT + 1) : 1;

  state_e           r_state, w_state_d;
  logic [IDW-1:0]   r_grant, r_ptr;
  logic             r_first_pend;
  logic [CNT_W-1:0] r_count;
  logic [LAT_W-1:0] r_wait;
  logic [Z_W-1:0]   r_res_data;
  logic [IDW-1:0]   r_res_id;
  logic [CNT_W-1:0] r_res_count;

  logic [NREQ-1:0]  w_gnt_onehot;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_any;
  logic             w_beat_valid;
  logic             w_beat_last;
  logic [A_W-1:0]   w_a;
  logic [B_W-1:0]   w_b;

  dsp_sched_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .i_req  (req_valid_i),
    .i_ptr  (r_ptr),
    .o_grant(w_gnt_onehot),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  assign w_beat_valid = req_valid_i[r_grant];
  assign w_beat_last  = req_last_i[r_grant];
  assign w_a          = req_a_i[32'(r_grant) * A_W +: A_W];
  assign w_b          = req_b_i[32'(r_grant) * B_W +: B_W];

  // Bubbles drive zero operands so the accumulator only ever adds 0 while waiting.
  always_comb begin
    w_state_d      = r_state;
    req_ready_o    = '0;
    dsp_a_o        = '0;
    dsp_b_o        = '0;
    dsp_load_acc_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_d = RUN;
      end
      RUN: begin
        req_ready_o[r_grant] = 1'b1;
        dsp_load_acc_o       = ~r_first_pend;
        if (w_beat_valid) begin
          dsp_a_o = w_a;
          dsp_b_o = w_b;
          if (w_beat_last) w_state_d = DRAIN;
        end
      end
      DRAIN: begin
        dsp_load_acc_o = 1'b1;
        if (r_wait == '0) w_state_d = RESULT;
      end
      RESULT: begin
        if (res_ready_i) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_first_pend <= 1'b0;
      r_count      <= '0;
      r_wait       <= '0;
      r_res_data   <= '0;
      r_res_id     <= '0;
      r_res_count  <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant      <= w_gnt_idx;
            r_first_pend <= 1'b1;
            r_count      <= '0;
          end
        end
        RUN: begin
          if (w_beat_valid) begin
            r_first_pend <= 1'b0;
            if (r_count != '1) r_count <= r_count + 1'b1;
            if (w_beat_last) r_wait <= LAT_W'(DSP_LAT);
          end
        end
        DRAIN: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else begin
            r_res_data  <= dsp_z_i;
            r_res_id    <= r_grant;
            r_res_count <= r_count;
          end
        end
        RESULT: begin
          if (res_ready_i) r_ptr <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_valid_o      = (r_state == RESULT);
  assign res_data_o       = r_res_data;
  assign res_id_o         = r_res_id;
  assign res_count_o      = r_res_count;
  assign dsp_feedback_o   = FB_ACC;
  assign dsp_unsigned_a_o = cfg_unsigned_a_i;
  assign dsp_unsigned_b_o = cfg_unsigned_b_i;
  assign dsp_subtract_o   = 1'b0;

`ifdef DSP_MAC_SCHED_SHIFT_EN
  assign dsp_shift_right_o = cfg_shift_i;
  assign dsp_round_o       = (cfg_shift_i != '0);
  assign dsp_saturate_o    = (cfg_shift_i != '0);
`else
  logic w_unused_shift;
  assign w_unused_shift    = ^cfg_shift_i;
  assign dsp_shift_right_o = '0;
  assign dsp_round_o       = 1'b0;
  assign dsp_saturate_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_job_scheduler.sv
// Directed bench for dsp_mac_job_scheduler with a behavioural one-cycle DSP MAC model.
module tb_dsp_mac_job_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [39:0] req_a;
  logic [35:0] req_b;
  logic [1:0]  req_last;
  logic        cfg_ua, cfg_ub;
  logic [5:0]  cfg_shift;
  logic        res_valid, res_ready;
  logic [37:0] res_data;
  logic [0:0]  res_id;
  logic [15:0] res_count;
  logic [19:0] dsp_a;
  logic [17:0] dsp_b;
  logic [2:0]  dsp_fb;
  logic        dsp_ld, dsp_ua, dsp_ub, dsp_sat, dsp_rnd, dsp_sub;
  logic [5:0]  dsp_shr;
  logic [37:0] dsp_z;

  int n_checks = 0;
  int n_errors = 0;

  dsp_mac_job_scheduler #(
    .NREQ(2),
    .DSP_LAT(1),
    .CNT_W(16)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_a_i          (req_a),
    .req_b_i          (req_b),
    .req_last_i       (req_last),
    .cfg_unsigned_a_i (cfg_ua),
    .cfg_unsigned_b_i (cfg_ub),
    .cfg_shift_i      (cfg_shift),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .res_data_o       (res_data),
    .res_id_o         (res_id),
    .res_count_o      (res_count),
    .dsp_a_o          (dsp_a),
    .dsp_b_o          (dsp_b),
    .dsp_feedback_o   (dsp_fb),
    .dsp_load_acc_o   (dsp_ld),
    .dsp_unsigned_a_o (dsp_ua),
    .dsp_unsigned_b_o (dsp_ub),
    .dsp_saturate_o   (dsp_sat),
    .dsp_round_o      (dsp_rnd),
    .dsp_subtract_o   (dsp_sub),
    .dsp_shift_right_o(dsp_shr),
    .dsp_z_i          (dsp_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered DSP MAC model: load_acc=0 loads the product, 1 accumulates it.
  logic signed [63:0] m_pa, m_pb, m_prod;
  assign m_pa   = dsp_ua ? $signed({44'd0, dsp_a}) : $signed({{44{dsp_a[19]}}, dsp_a});
  assign m_pb   = dsp_ub ? $signed({46'd0, dsp_b}) : $signed({{46{dsp_b[17]}}, dsp_b});
  assign m_prod = m_pa * m_pb;
  always @(posedge clk) dsp_z <= dsp_ld ? dsp_z + m_prod[37:0] : m_prod[37:0];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one beat, wait for the handshake and check what reaches the DSP.
  task automatic beat(input int r, input logic [19:0] a, input logic [17:0] b,
                      input logic last, input logic exp_ld);
    int t = 0;
    req_valid[r]       = 1'b1;
    req_a[r*20 +: 20]  = a;
    req_b[r*18 +: 18]  = b;
    req_last[r]        = last;
    @(negedge clk);
    while (!req_ready[r] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("beat_ready_timeout", 64'(req_ready[r]), 64'd1);
    check("beat_dsp_a", 64'(dsp_a), 64'(a));
    check("beat_load_acc", 64'(dsp_ld), 64'(exp_ld));
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic collect(input logic [37:0] data, input logic [0:0] id, input int cnt);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!res_valid && t < 50);
    check("res_valid", 64'(res_valid), 64'd1);
    check("res_data", 64'(res_data), 64'(data));
    check("res_id", 64'(res_id), 64'(id));
    check("res_count", 64'(res_count), 64'(cnt));
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (req_ready == 2'b00 && t < 50);
    g = req_ready;
  endtask

  logic [1:0] g;

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_last = '0;
    cfg_ua = 1'b0; cfg_ub = 1'b0; cfg_shift = '0; res_ready = 1'b0;
    rst = 1'b1;
    do_reset();

    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_load_acc", 64'(dsp_ld), 64'd0);
    check("rst_feedback", 64'(dsp_fb), 64'd0);
    check("rst_subtract", 64'(dsp_sub), 64'd0);
    check("rst_dsp_a", 64'(dsp_a), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    @(posedge clk); #1;

    // 1: three-beat signed job, result latency
    beat(0, 20'd3, 18'd2, 1'b0, 1'b0);
    beat(0, 20'd4, 18'd2, 1'b0, 1'b1);
    beat(0, 20'd5, 18'd2, 1'b1, 1'b1);
    @(negedge clk); check("t1_lat_drain0", 64'(res_valid), 64'd0);
    @(negedge clk); check("t1_lat_drain1", 64'(res_valid), 64'd0);
    @(negedge clk); check("t1_lat_valid", 64'(res_valid), 64'd1);
    collect(38'd24, 1'b0, 3);

    // 2: contention after reset, round-robin order
    do_reset();
    req_a = {20'd2, 20'd1}; req_b = {18'd1, 18'd1}; req_last = 2'b11; req_valid = 2'b11;
    wait_grant(g); check("t2_grant_first", 64'(g), 64'b01);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    collect(38'd1, 1'b0, 1);
    wait_grant(g); check("t2_grant_second", 64'(g), 64'b10);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    collect(38'd2, 1'b1, 1);
    req_valid = 2'b11;
    wait_grant(g); check("t2_grant_third", 64'(g), 64'b01);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    collect(38'd1, 1'b0, 1);
    wait_grant(g); check("t2_grant_fourth", 64'(g), 64'b10);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    collect(38'd2, 1'b1, 1);
    req_last = 2'b00;

    // 3: single negative beat on requester 1
    beat(1, 20'hFFFF9, 18'd6, 1'b1, 1'b0);
    collect(38'h3FFFFFFFD6, 1'b1, 1);

    // 4: bubbles within a job, then a held result
    for (int i = 0; i < 4; i++) begin
      beat(0, 20'd1, 18'd1, (i == 3), (i != 0));
      if (i != 3) begin
        repeat (2) begin
          @(negedge clk);
          check("t4_bubble_a", 64'(dsp_a), 64'd0);
          check("t4_bubble_ld", 64'(dsp_ld), 64'd1);
          @(posedge clk); #1;
        end
      end
    end
    req_a[39:20] = 20'd9; req_b[35:18] = 18'd9; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    begin
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!res_valid && t < 50);
    end
    check("t4_hold_count", 64'(res_count), 64'd4);
    repeat (5) begin
      check("t4_hold_valid", 64'(res_valid), 64'd1);
      check("t4_hold_data", 64'(res_data), 64'd4);
      check("t4_hold_nogrant", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; req_valid[1] = 1'b0; req_last[1] = 1'b0;
    @(negedge clk);
    check("t4_after_ack_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;

    // 5: reset in the middle of a job
    beat(0, 20'd7, 18'd7, 1'b0, 1'b0);
    beat(0, 20'd7, 18'd7, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_result", 64'(res_valid), 64'd0);
      check("t5_no_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    beat(0, 20'd2, 18'd3, 1'b1, 1'b0);
    collect(38'd6, 1'b0, 1);

    // 6: shift/round/saturate controls
    cfg_shift = 6'd2;
    #1;
`ifdef DSP_MAC_SCHED_SHIFT_EN
    check("t6_shift", 64'(dsp_shr), 64'd2);
    check("t6_round", 64'(dsp_rnd), 64'd1);
    check("t6_saturate", 64'(dsp_sat), 64'd1);
`else
    check("t6_shift", 64'(dsp_shr), 64'd0);
    check("t6_round", 64'(dsp_rnd), 64'd0);
    check("t6_saturate", 64'(dsp_sat), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
